// File: rtl/pipeline_sink.sv
// Output-end sink of the global-stall address pipeline: buffers beats in a small FIFO,
// stalls the pipeline when full, purges flushed IDs and presents survivors downstream.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module pipeline_sink #(
  parameter int ADDR_W     = `ADDRESS_WIDTH,
  parameter int IDW        = `ID_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             pipe_address,
  input  logic [IDW-1:0]                pipe_id,
  input  logic                          pipe_valid,
  output logic                          pipe_stall,
  input  logic                          flush,
  input  logic [IDW-1:0]                flush_id,
  output logic [ADDR_W-1:0]             m_address,
  output logic [IDW-1:0]                m_id,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0]     mem_addr [FIFO_DEPTH];
  logic [IDW-1:0]        mem_id   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] kill, kill_next;
  logic [FIFO_DEPTH-1:0] occupied;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;

  logic full, accept, in_match, push, in_drop, head_kill, pop;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;

  // Stall comes from registered state only, so it never closes a loop through the pipeline.
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign pipe_stall = full;

  assign accept    = pipe_valid && !full;
  assign in_match  = flush && (flush_id == pipe_id);
  assign push      = accept && !in_match;
  assign in_drop   = accept && in_match;

  assign head_kill = (count != '0) && kill[rd_ptr];
  assign m_valid   = (count != '0) && !kill[rd_ptr];
  assign pop       = (m_valid && m_ready) || head_kill;

  assign m_address = mem_addr[rd_ptr];
  assign m_id      = mem_id[rd_ptr];
  assign occupancy = count;

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_occ
    logic [PW-1:0] offs;
    assign offs        = PW'(g) - rd_ptr;
    assign occupied[g] = ({1'b0, offs} < count);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    kill_next = kill;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (flush && occupied[i] && (mem_id[i] == flush_id)) kill_next[i] = 1'b1;
    end
    if (push) kill_next[wr_ptr] = 1'b0;
  end

  assign drop_inc = {1'b0, in_drop} + {1'b0, head_kill};
  assign drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);

  // NOTE: payload storage has no reset; count and kill bits alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= pipe_address;
      mem_id[wr_ptr]   <= pipe_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      kill       <= '0;
      drop_count <= '0;
    end else begin
      kill <= kill_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      drop_count <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed bench for pipeline_sink: scoreboard of expected deliveries checked by a
// negedge monitor, plus direct checks of stall, occupancy and drop counting.
module tb_pipeline_sink;

  localparam int ADDR_W = 16;
  localparam int IDW    = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [IDW-1:0]    id;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pipe_address;
  logic [IDW-1:0]    pipe_id;
  logic              pipe_valid;
  logic              pipe_stall;
  logic              flush;
  logic [IDW-1:0]    flush_id;
  logic [ADDR_W-1:0] m_address;
  logic [IDW-1:0]    m_id;
  logic              m_valid;
  logic              m_ready;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]  drop_count;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_deliv = 0;
  int    deliv_mark;
  beat_t sb[$];

  pipeline_sink #(.ADDR_W(ADDR_W), .IDW(IDW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pipe_address(pipe_address), .pipe_id(pipe_id), .pipe_valid(pipe_valid),
    .pipe_stall(pipe_stall), .flush(flush), .flush_id(flush_id),
    .m_address(m_address), .m_id(m_id), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDW-1:0] id);
    return 16'hA000 | (ADDR_W'(id) << 4) | 16'h3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IDW-1:0] id, input logic expect_out);
    pipe_valid   = 1'b1;
    pipe_id      = id;
    pipe_address = addr_of(id);
    if (expect_out) sb.push_back('{addr: addr_of(id), id: id});
  endtask

  // Handshake seen at negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      beat_t exp_b;
      n_deliv++;
      check("deliv_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("deliv_id", 32'(m_id), 32'(exp_b.id));
        check("deliv_addr", 32'(m_address), 32'(exp_b.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; pipe_valid = 1'b0; pipe_id = '0; pipe_address = '0;
    flush = 1'b0; flush_id = '0; m_ready = 1'b0;
    #2;
    check("rst_stall", 32'(pipe_stall), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_drop", 32'(drop_count), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: streaming with m_ready=1, one beat per cycle
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      drive(IDW'(i), 1'b1);
      tick();
      check("t1_m_valid", 32'(m_valid), 1);
      check("t1_m_id", 32'(m_id), 32'(i));
      check("t1_stall", 32'(pipe_stall), 0);
      check("t1_occ", 32'(occupancy), 1);
    end
    pipe_valid = 1'b0;
    tick();
    check("t1_occ_end", 32'(occupancy), 0);
    check("t1_drop", 32'(drop_count), 0);
    check("t1_sb_empty", 32'(sb.size()), 0);
    check("t1_deliv", 32'(n_deliv), 6);

    // 2: fill to full, hold 5th beat on pipe side, release with one pop
    m_ready = 1'b0;
    deliv_mark = n_deliv;
    for (int i = 1; i <= 4; i++) begin
      drive(IDW'(i), 1'b1);
      tick();
      check("t2_occ", 32'(occupancy), 32'(i));
      check("t2_stall", 32'(pipe_stall), 32'(i == 4));
    end
    drive(4'd5, 1'b0);
    tick();
    check("t2_hold_occ", 32'(occupancy), 4);
    check("t2_hold_stall", 32'(pipe_stall), 1);
    tick();
    check("t2_hold_occ2", 32'(occupancy), 4);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t2_pop_occ", 32'(occupancy), 3);
    check("t2_pop_stall", 32'(pipe_stall), 0);
    sb.push_back('{addr: addr_of(4'd5), id: 4'd5});
    tick();
    pipe_valid = 1'b0;
    check("t2_cap5_occ", 32'(occupancy), 4);
    check("t2_cap5_stall", 32'(pipe_stall), 1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t2_drain_occ", 32'(occupancy), 0);
    check("t2_deliv", 32'(n_deliv - deliv_mark), 5);
    check("t2_sb_empty", 32'(sb.size()), 0);

    // 3: buffered flush of ID 3, only ID 7 survives
    m_ready = 1'b0;
    deliv_mark = n_deliv;
    drive(4'd3, 1'b0); tick();
    drive(4'd7, 1'b1); tick();
    drive(4'd3, 1'b0); tick();
    pipe_valid = 1'b0;
    check("t3_occ", 32'(occupancy), 3);
    flush = 1'b1; flush_id = 4'd3;
    tick();
    flush = 1'b0;
    check("t3_killed_occ", 32'(occupancy), 3);
    check("t3_head_hidden", 32'(m_valid), 0);
    check("t3_drop0", 32'(drop_count), 0);
    m_ready = 1'b1;
    tick();
    check("t3_drop1", 32'(drop_count), 1);
    check("t3_m_valid7", 32'(m_valid), 1);
    check("t3_m_id7", 32'(m_id), 7);
    tick(); tick();
    check("t3_occ_end", 32'(occupancy), 0);
    check("t3_drop2", 32'(drop_count), 2);
    check("t3_deliv", 32'(n_deliv - deliv_mark), 1);

    // 4: incoming drop, then flush racing a completing handshake
    m_ready = 1'b0;
    drive(4'd5, 1'b1); tick();
    check("t4_occ1", 32'(occupancy), 1);
    drive(4'd9, 1'b0);
    flush = 1'b1; flush_id = 4'd9;
    tick();
    flush = 1'b0; pipe_valid = 1'b0;
    check("t4_in_drop_occ", 32'(occupancy), 1);
    check("t4_in_drop_cnt", 32'(drop_count), 3);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    drive(4'd9, 1'b1); tick();
    pipe_valid = 1'b0;
    check("t4_head9", 32'(m_id), 9);
    deliv_mark = n_deliv;
    flush = 1'b1; flush_id = 4'd9; m_ready = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b0;
    check("t4_race_deliv", 32'(n_deliv - deliv_mark), 1);
    check("t4_race_occ", 32'(occupancy), 0);
    check("t4_race_drop", 32'(drop_count), 3);

    // 5: drop counter saturation with a double-discard cycle
    drive(4'd1, 1'b0);
    flush = 1'b1; flush_id = 4'd1;
    for (int i = 0; i < 251; i++) tick();
    flush = 1'b0; pipe_valid = 1'b0;
    check("t5_drop254", 32'(drop_count), 254);
    drive(4'd2, 1'b0); tick();
    pipe_valid = 1'b0;
    flush = 1'b1; flush_id = 4'd2;
    tick();
    check("t5_killed_hidden", 32'(m_valid), 0);
    check("t5_not_counted_yet", 32'(drop_count), 254);
    drive(4'd2, 1'b0);
    tick();
    check("t5_sat255", 32'(drop_count), 255);
    check("t5_occ0", 32'(occupancy), 0);
    tick();
    flush = 1'b0; pipe_valid = 1'b0;
    check("t5_stay255", 32'(drop_count), 255);

    // 6: asynchronous reset while full and stalled
    for (int i = 4; i <= 7; i++) begin
      drive(IDW'(i), 1'b0); tick();
    end
    pipe_valid = 1'b0;
    check("t6_full_stall", 32'(pipe_stall), 1);
    check("t6_full_occ", 32'(occupancy), 4);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_stall", 32'(pipe_stall), 0);
    check("t6_async_m_valid", 32'(m_valid), 0);
    check("t6_async_occ", 32'(occupancy), 0);
    check("t6_async_drop", 32'(drop_count), 0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_post_m_valid", 32'(m_valid), 0);
    deliv_mark = n_deliv;
    m_ready = 1'b1;
    drive(4'd12, 1'b1); tick();
    pipe_valid = 1'b0;
    check("t6_new_m_valid", 32'(m_valid), 1);
    check("t6_new_m_id", 32'(m_id), 12);
    tick(); tick();
    check("t6_occ_end", 32'(occupancy), 0);
    check("t6_deliv", 32'(n_deliv - deliv_mark), 1);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
